// File: rtl/raster_line_sequencer_if.sv
// Raster sequencer bundle: raw opto strobe in, beam position and status out.
// Pure wiring, no latency.
// No backpressure: the strobe is fire-and-forget and outputs are always valid.
`timescale 1ns/1ps
interface raster_line_sequencer_if;
   logic       x_axis_stb;
   logic [8:0] row;
   logic [9:0] col;
   logic       pixel_valid;
   logic       line_start;
   logic       frame_start;
   logic [1:0] state;
   logic       stall;

   // Stimulus side: drives the strobe, observes the sequencer
   modport master (
      output x_axis_stb,
      input  row, col, pixel_valid, line_start, frame_start, state, stall
   );

   // Sequencer side
   modport slave (
      input  x_axis_stb,
      output row, col, pixel_valid, line_start, frame_start, state, stall
   );
endinterface

// File: rtl/raster_line_sequencer.sv
// Tracks beam row/column for a mirror-scanned display from a raw x-axis strobe; RLS_STB_WATCHDOG_EN adds a strobe watchdog.
// Latency: line_start and all row/col/state updates appear 3 clocks after the first edge that samples the strobe high.
// No backpressure: every detected strobe edge is accepted; the column scan free-runs between strobes.
`timescale 1ns/1ps
module raster_line_sequencer #(
   parameter int NUM_ROWS     = 240,
   parameter int NUM_COLS     = 320,
   parameter int RETURN_LINES = 25,
   parameter int CLKS_PER_COL = 8,
   parameter int STB_TIMEOUT  = 1000000
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   raster_line_sequencer_if.slave  bus
);
   localparam int ROW_W = (NUM_ROWS + RETURN_LINES > 1) ? $clog2(NUM_ROWS + RETURN_LINES) : 1;
   localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int PRE_W = (CLKS_PER_COL > 1) ? $clog2(CLKS_PER_COL) : 1;

   localparam logic [ROW_W-1:0] ROW_DISP_LAST = ROW_W'(NUM_ROWS - 1);
   localparam logic [ROW_W-1:0] ROW_RET_FIRST = ROW_W'(NUM_ROWS);
   localparam logic [ROW_W-1:0] ROW_RET_LAST  = ROW_W'(NUM_ROWS + RETURN_LINES - 1);
   localparam logic [COL_W-1:0] COL_LAST      = COL_W'(NUM_COLS - 1);
   localparam logic [PRE_W-1:0] PRE_LAST      = PRE_W'(CLKS_PER_COL - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DISPLAY = 2'd1,
      ST_RETURN  = 2'd2
   } state_t;

   state_t           state_q, state_nxt;
   logic [ROW_W-1:0] row_q, row_nxt;
   logic [COL_W-1:0] col_q, col_nxt;
   logic [PRE_W-1:0] pre_q, pre_nxt;
   logic             pv_q, pv_nxt;
   logic             fs_q, fs_nxt;
   logic             ls_q;
   logic             sync1_q, sync2_q, sync2_d_q, edge_q;
   logic             stb_edge;
   logic             trip;

   assign stb_edge = sync2_q & ~sync2_d_q;

   // Two-flop synchroniser, edge history and one pipeline stage ahead of the update point
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         sync2_d_q <= 1'b0;
         edge_q    <= 1'b0;
      end else begin
         sync1_q   <= bus.x_axis_stb;
         sync2_q   <= sync1_q;
         sync2_d_q <= sync2_q;
         edge_q    <= stb_edge;
      end
   end

`ifdef RLS_STB_WATCHDOG_EN
   localparam int WD_W = (STB_TIMEOUT > 1) ? $clog2(STB_TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(STB_TIMEOUT - 1);

   logic [WD_W-1:0] wd_q;
   logic            stall_q;

   // Clocks since the last detected edge; parks at the trip value until the next edge
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)                wd_q <= '0;
      else if (stb_edge)        wd_q <= '0;
      else if (wd_q != WD_LAST) wd_q <= wd_q + 1'b1;
   end

   assign trip = (wd_q == WD_LAST) && !stb_edge;

   // Stall sets on a trip and clears when the next strobe is accepted
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)       stall_q <= 1'b0;
      else if (edge_q) stall_q <= 1'b0;
      else if (trip)   stall_q <= 1'b1;
   end

   assign bus.stall = stall_q;
`else
   // Without the watchdog the timeout is meaningless; this is constant false
   assign trip      = (STB_TIMEOUT < 0);
   assign bus.stall = 1'b0;
`endif

   // Next-state: column prescaler free-runs; an accepted strobe restarts the line and steps the row FSM
   always_comb begin
      state_nxt = state_q;
      row_nxt   = row_q;
      col_nxt   = col_q;
      pre_nxt   = pre_q;
      pv_nxt    = pv_q;
      fs_nxt    = 1'b0;

      if (pre_q == PRE_LAST) begin
         pre_nxt = '0;
         if (col_q == COL_LAST) pv_nxt  = 1'b0;
         else                   col_nxt = col_q + 1'b1;
      end else begin
         pre_nxt = pre_q + 1'b1;
      end

      if (edge_q) begin
         col_nxt = '0;
         pre_nxt = '0;
         case (state_q)
            ST_DISPLAY: begin
               if (row_q == ROW_DISP_LAST) begin
                  row_nxt   = ROW_RET_FIRST;
                  state_nxt = ST_RETURN;
               end else begin
                  row_nxt = row_q + 1'b1;
               end
            end
            ST_RETURN: begin
               if (row_q == ROW_RET_LAST) begin
                  row_nxt   = '0;
                  state_nxt = ST_DISPLAY;
                  fs_nxt    = 1'b1;
               end else begin
                  row_nxt = row_q + 1'b1;
               end
            end
            default: begin
               row_nxt   = ROW_RET_FIRST;
               state_nxt = ST_RETURN;
            end
         endcase
         pv_nxt = (state_nxt == ST_DISPLAY);
      end else if (trip) begin
         state_nxt = ST_IDLE;
         pv_nxt    = 1'b0;
      end
   end

   // State and position registers; reset parks the beam at the start of flyback
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= ST_RETURN;
         row_q   <= ROW_RET_FIRST;
         col_q   <= '0;
         pre_q   <= '0;
         pv_q    <= 1'b0;
         fs_q    <= 1'b0;
         ls_q    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         row_q   <= row_nxt;
         col_q   <= col_nxt;
         pre_q   <= pre_nxt;
         pv_q    <= pv_nxt;
         fs_q    <= fs_nxt;
         ls_q    <= edge_q;
      end
   end

   assign bus.row         = 9'(row_q);
   assign bus.col         = 10'(col_q);
   assign bus.pixel_valid = pv_q;
   assign bus.line_start  = ls_q;
   assign bus.frame_start = fs_q;
   assign bus.state       = state_q;
endmodule
